// File: rtl/mem_port_arbiter_if.sv
// Bus bundle linking the I-cache, D-cache and single-port main memory to mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
);
    logic [1:0]                  i_req_signal;
    logic [ADDR_WIDTH-1:0]       i_req_addr;
    logic [LEN-1:0]              i_data;
    logic                        i_data_valid;
    logic                        i_done;

    logic [1:0]                  d_req_signal;
    logic [ADDR_WIDTH-1:0]       d_req_addr;
    logic [ENTRY_INDEX_SIZE:0]   d_req_length;
    logic [2:0]                  d_req_data_type;
    logic [LEN-1:0]              d_req_written_data;
    logic [ENTRY_INDEX_SIZE:0]   d_beat_idx;
    logic [LEN-1:0]              d_data;
    logic                        d_data_valid;
    logic                        d_done;

    logic [1:0]                  mem_i_vis_signal;
    logic [1:0]                  mem_d_vis_signal;
    logic [ADDR_WIDTH-1:0]       mem_i_vis_addr;
    logic [ADDR_WIDTH-1:0]       mem_d_vis_addr;
    logic [ENTRY_INDEX_SIZE:0]   mem_length;
    logic [LEN-1:0]              mem_written_data;
    logic [2:0]                  mem_data_type;
    logic [LEN-1:0]              mem_data;
    logic [1:0]                  mem_status;

    modport slave (
        input  i_req_signal, i_req_addr,
        output i_data, i_data_valid, i_done,
        input  d_req_signal, d_req_addr, d_req_length, d_req_data_type, d_req_written_data,
        output d_beat_idx, d_data, d_data_valid, d_done,
        output mem_i_vis_signal, mem_d_vis_signal, mem_i_vis_addr, mem_d_vis_addr,
        output mem_length, mem_written_data, mem_data_type,
        input  mem_data, mem_status
    );

    modport master (
        output i_req_signal, i_req_addr,
        input  i_data, i_data_valid, i_done,
        output d_req_signal, d_req_addr, d_req_length, d_req_data_type, d_req_written_data,
        input  d_beat_idx, d_data, d_data_valid, d_done,
        input  mem_i_vis_signal, mem_d_vis_signal, mem_i_vis_addr, mem_d_vis_addr,
        input  mem_length, mem_written_data, mem_data_type,
        output mem_data, mem_status
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between I-cache and D-cache (D has priority).
// Optional starvation guard for instruction fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int ENTRY_INDEX_SIZE = 3
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT     = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    localparam int BW = ENTRY_INDEX_SIZE + 1;

    localparam logic [1:0] MEM_NOP          = 2'b00;
    localparam logic [1:0] MEM_READ         = 2'b01;
    localparam logic [1:0] MEM_READ_BURST   = 2'b10;
    localparam logic [1:0] MEM_DATA_WORKING = 2'b01;
    localparam logic [1:0] MEM_FINISHED     = 2'b10;
    localparam logic [2:0] FOUR_BYTE        = 3'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state;
    logic                  owner_d;
    logic [1:0]            req_type;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [BW-1:0]         length;
    logic [2:0]            data_type;
    logic [BW-1:0]         beat;
    logic                  done_r;

    logic                  i_forced;
    logic                  grant_d;
    logic                  grant_i;
    logic                  active;
    logic                  finished;
    logic                  rd_beat;
    logic [ADDR_WIDTH-1:0] beat_addr;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v == {BW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic is_read(input logic [1:0] t);
        return (t == MEM_READ) || (t == MEM_READ_BURST);
    endfunction

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve;

    assign i_forced = (starve == SW'(STARVE_LIMIT)) && (bus.i_req_signal != MEM_NOP);

    // Counts D grants that bypassed a waiting I request; cannot pass the limit
    // because reaching it hands the next grant to I.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (grant_i) begin
                starve <= '0;
            end else if (grant_d && (bus.i_req_signal != MEM_NOP)) begin
                starve <= starve + 1'b1;
            end
        end
    end
`else
    assign i_forced = 1'b0;
`endif

    assign grant_d = (bus.d_req_signal != MEM_NOP) && !i_forced;
    assign grant_i = (bus.i_req_signal != MEM_NOP) && ((bus.d_req_signal == MEM_NOP) || i_forced);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            req_type  <= MEM_NOP;
            base_addr <= '0;
            length    <= '0;
            data_type <= '0;
            beat      <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d   <= 1'b1;
                        req_type  <= bus.d_req_signal;
                        base_addr <= bus.d_req_addr;
                        length    <= bus.d_req_length;
                        data_type <= bus.d_req_data_type;
                        beat      <= '0;
                        state     <= ISSUE;
                    end else if (grant_i) begin
                        owner_d   <= 1'b0;
                        req_type  <= bus.i_req_signal;
                        base_addr <= bus.i_req_addr;
                        length    <= '0;
                        data_type <= FOUR_BYTE;
                        beat      <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    beat  <= sat_inc(beat);
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_status == MEM_FINISHED) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else if (bus.mem_status == MEM_DATA_WORKING) begin
                        beat <= sat_inc(beat);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign active    = (state == ISSUE) || (state == WAIT);
    assign finished  = (state == WAIT) && (bus.mem_status == MEM_FINISHED);
    assign rd_beat   = (state == WAIT) && is_read(req_type);
    assign beat_addr = base_addr + ADDR_WIDTH'({beat, 2'b00});

    // The request is withdrawn in the finishing cycle itself so memory does not restart.
    assign bus.mem_d_vis_signal = (active && !finished) ? req_type : MEM_NOP;
    assign bus.mem_i_vis_signal = MEM_NOP;
    assign bus.mem_i_vis_addr   = active ? beat_addr : '0;
    assign bus.mem_d_vis_addr   = active ? beat_addr : '0;
    assign bus.mem_length       = length;
    assign bus.mem_data_type    = data_type;
    assign bus.mem_written_data = bus.d_req_written_data;
    assign bus.d_beat_idx       = beat;

    assign bus.i_data_valid = rd_beat && !owner_d;
    assign bus.d_data_valid = rd_beat && owner_d;
    assign bus.i_data       = bus.i_data_valid ? bus.mem_data : '0;
    assign bus.d_data       = bus.d_data_valid ? bus.mem_data : '0;
    assign bus.i_done       = done_r && !owner_d;
    assign bus.d_done       = done_r && owner_d;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory responses are scripted cycle by cycle.
module tb_mem_port_arbiter;
    localparam logic [1:0] MEM_NOP          = 2'b00;
    localparam logic [1:0] MEM_READ         = 2'b01;
    localparam logic [1:0] MEM_READ_BURST   = 2'b10;
    localparam logic [1:0] MEM_WRITE        = 2'b11;
    localparam logic [1:0] ST_IDLE          = 2'b00;
    localparam logic [1:0] MEM_DATA_WORKING = 2'b01;
    localparam logic [1:0] MEM_FINISHED     = 2'b10;
    localparam logic [2:0] FOUR_BYTE        = 3'd2;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(17), .LEN(32), .ENTRY_INDEX_SIZE(3)) bus ();

    mem_port_arbiter #(.ADDR_WIDTH(17), .LEN(32), .ENTRY_INDEX_SIZE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req_signal       = MEM_NOP;
        bus.i_req_addr         = '0;
        bus.d_req_signal       = MEM_NOP;
        bus.d_req_addr         = '0;
        bus.d_req_length       = '0;
        bus.d_req_data_type    = '0;
        bus.d_req_written_data = '0;
        bus.mem_data           = '0;
        bus.mem_status         = ST_IDLE;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (bus.mem_d_vis_signal !== MEM_NOP) begin n_fail++; $display("FAIL reset_sig: got %b want %b", bus.mem_d_vis_signal, MEM_NOP); end
        n_checks++; if (bus.mem_d_vis_addr !== 17'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_d_vis_addr); end
        n_checks++; if ({bus.i_done, bus.d_done, bus.i_data_valid, bus.d_data_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.i_done, bus.d_done, bus.i_data_valid, bus.d_data_valid}); end
        n_checks++; if (bus.d_beat_idx !== 4'd0) begin n_fail++; $display("FAIL reset_beat: got %0d want 0", bus.d_beat_idx); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_i_single_read();
        bus.i_req_signal = MEM_READ;
        bus.i_req_addr   = 17'h100;
        tick();
        n_checks++; if (bus.mem_i_vis_addr !== 17'h100) begin n_fail++; $display("FAIL i_issue_iaddr: got %h want 100", bus.mem_i_vis_addr); end
        n_checks++; if (bus.mem_d_vis_addr !== 17'h100) begin n_fail++; $display("FAIL i_issue_daddr: got %h want 100", bus.mem_d_vis_addr); end
        n_checks++; if (bus.mem_d_vis_signal !== MEM_READ) begin n_fail++; $display("FAIL i_issue_sig: got %b want %b", bus.mem_d_vis_signal, MEM_READ); end
        n_checks++; if (bus.mem_i_vis_signal !== MEM_NOP) begin n_fail++; $display("FAIL i_issue_isig: got %b want 00", bus.mem_i_vis_signal); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL i_issue_busy: got %b want 1", busy); end
        tick();
        bus.mem_status = MEM_FINISHED;
        bus.mem_data   = 32'hCAFE_0001;
        #1;
        n_checks++; if (bus.i_data_valid !== 1'b1) begin n_fail++; $display("FAIL i_wait_valid: got %b want 1", bus.i_data_valid); end
        n_checks++; if (bus.i_data !== 32'hCAFE_0001) begin n_fail++; $display("FAIL i_wait_data: got %h want cafe0001", bus.i_data); end
        n_checks++; if ({bus.d_data_valid, bus.d_data} !== 33'h0) begin n_fail++; $display("FAIL i_wait_dside: got %b/%h want 0/0", bus.d_data_valid, bus.d_data); end
        n_checks++; if (bus.mem_d_vis_signal !== MEM_NOP) begin n_fail++; $display("FAIL i_fin_sig: got %b want 00", bus.mem_d_vis_signal); end
        n_checks++; if (bus.i_done !== 1'b0) begin n_fail++; $display("FAIL i_early_done: got %b want 0", bus.i_done); end
        tick();
        bus.mem_status   = ST_IDLE;
        bus.i_req_signal = MEM_NOP;
        #1;
        n_checks++; if ({bus.i_done, bus.d_done} !== 2'b10) begin n_fail++; $display("FAIL i_done: got %b want 10", {bus.i_done, bus.d_done}); end
        n_checks++; if ({bus.i_data_valid, bus.i_data} !== 33'h0) begin n_fail++; $display("FAIL i_done_data: got %b/%h want 0/0", bus.i_data_valid, bus.i_data); end
        tick();
        n_checks++; if ({busy, bus.i_done} !== 2'b00) begin n_fail++; $display("FAIL i_back_idle: got %b want 00", {busy, bus.i_done}); end
    endtask

    task automatic test_d_burst_read();
        logic [16:0] exp_addr;
        bus.d_req_signal    = MEM_READ_BURST;
        bus.d_req_addr      = 17'h40;
        bus.d_req_length    = 4'd4;
        bus.d_req_data_type = FOUR_BYTE;
        tick();
        n_checks++; if (bus.mem_d_vis_addr !== 17'h40) begin n_fail++; $display("FAIL burst_addr0: got %h want 40", bus.mem_d_vis_addr); end
        n_checks++; if (bus.mem_d_vis_signal !== MEM_READ_BURST) begin n_fail++; $display("FAIL burst_issue_sig: got %b want 10", bus.mem_d_vis_signal); end
        n_checks++; if (bus.mem_length !== 4'd4) begin n_fail++; $display("FAIL burst_len: got %0d want 4", bus.mem_length); end
        tick();
        for (int j = 0; j < 3; j++) begin
            bus.mem_status = (j < 2) ? MEM_DATA_WORKING : MEM_FINISHED;
            bus.mem_data   = 32'h1000 + j;
            exp_addr       = 17'h44 + 17'(4 * j);
            #1;
            n_checks++; if (bus.mem_d_vis_addr !== exp_addr) begin n_fail++; $display("FAIL burst_addr%0d: got %h want %h", j + 1, bus.mem_d_vis_addr, exp_addr); end
            n_checks++; if ({bus.d_data_valid, bus.d_data} !== {1'b1, 32'h1000 + j}) begin n_fail++; $display("FAIL burst_beat%0d: got %b/%h want 1/%h", j, bus.d_data_valid, bus.d_data, 32'h1000 + j); end
            n_checks++; if (bus.mem_d_vis_signal !== ((j < 2) ? MEM_READ_BURST : MEM_NOP)) begin n_fail++; $display("FAIL burst_sig%0d: got %b", j, bus.mem_d_vis_signal); end
            n_checks++; if (bus.d_done !== 1'b0) begin n_fail++; $display("FAIL burst_early_done%0d: got 1 want 0", j); end
            tick();
        end
        bus.mem_status   = ST_IDLE;
        bus.d_req_signal = MEM_NOP;
        #1;
        n_checks++; if ({bus.d_done, bus.i_done, bus.d_data_valid} !== 3'b100) begin n_fail++; $display("FAIL burst_done: got %b want 100", {bus.d_done, bus.i_done, bus.d_data_valid}); end
        tick();
        n_checks++; if ({busy, bus.d_done} !== 2'b00) begin n_fail++; $display("FAIL burst_idle: got %b want 00", {busy, bus.d_done}); end
    endtask

    task automatic test_d_write();
        bus.d_req_signal       = MEM_WRITE;
        bus.d_req_addr         = 17'h200;
        bus.d_req_length       = 4'd2;
        bus.d_req_data_type    = FOUR_BYTE;
        bus.d_req_written_data = 32'hAAAA_0000;
        tick();
        n_checks++; if (bus.d_beat_idx !== 4'd0) begin n_fail++; $display("FAIL wr_beat0: got %0d want 0", bus.d_beat_idx); end
        n_checks++; if (bus.mem_written_data !== 32'hAAAA_0000) begin n_fail++; $display("FAIL wr_data0: got %h want aaaa0000", bus.mem_written_data); end
        n_checks++; if ({bus.mem_length, bus.mem_data_type} !== {4'd2, FOUR_BYTE}) begin n_fail++; $display("FAIL wr_len_type: got %0d/%0d want 2/2", bus.mem_length, bus.mem_data_type); end
        n_checks++; if (bus.mem_d_vis_signal !== MEM_WRITE) begin n_fail++; $display("FAIL wr_sig: got %b want 11", bus.mem_d_vis_signal); end
        tick();
        bus.d_req_written_data = 32'hAAAA_0001;
        bus.mem_status         = MEM_FINISHED;
        #1;
        n_checks++; if (bus.d_beat_idx !== 4'd1) begin n_fail++; $display("FAIL wr_beat1: got %0d want 1", bus.d_beat_idx); end
        n_checks++; if (bus.mem_written_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL wr_data1: got %h want aaaa0001", bus.mem_written_data); end
        n_checks++; if (bus.mem_d_vis_addr !== 17'h204) begin n_fail++; $display("FAIL wr_addr1: got %h want 204", bus.mem_d_vis_addr); end
        n_checks++; if ({bus.d_data_valid, bus.mem_d_vis_signal} !== 3'b000) begin n_fail++; $display("FAIL wr_fin: got %b want 000", {bus.d_data_valid, bus.mem_d_vis_signal}); end
        tick();
        bus.mem_status   = ST_IDLE;
        bus.d_req_signal = MEM_NOP;
        #1;
        n_checks++; if (bus.d_done !== 1'b1) begin n_fail++; $display("FAIL wr_done: got %b want 1", bus.d_done); end
        tick();
    endtask

    task automatic test_simultaneous();
        bus.i_req_signal = MEM_READ;
        bus.i_req_addr   = 17'h300;
        bus.d_req_signal = MEM_READ;
        bus.d_req_addr   = 17'h400;
        tick();
        n_checks++; if (bus.mem_d_vis_addr !== 17'h400) begin n_fail++; $display("FAIL sim_d_first: got %h want 400", bus.mem_d_vis_addr); end
        tick();
        bus.mem_status = MEM_FINISHED;
        bus.mem_data   = 32'h0000_D00D;
        #1;
        n_checks++; if ({bus.d_data_valid, bus.i_data_valid} !== 2'b10) begin n_fail++; $display("FAIL sim_d_valid: got %b want 10", {bus.d_data_valid, bus.i_data_valid}); end
        tick();
        bus.mem_status   = ST_IDLE;
        bus.d_req_signal = MEM_NOP;
        #1;
        n_checks++; if ({bus.d_done, bus.i_done} !== 2'b10) begin n_fail++; $display("FAIL sim_d_done: got %b want 10", {bus.d_done, bus.i_done}); end
        tick();
        n_checks++; if ({busy, bus.mem_d_vis_signal} !== 3'b000) begin n_fail++; $display("FAIL sim_gap_idle: got %b want 000", {busy, bus.mem_d_vis_signal}); end
        tick();
        n_checks++; if (bus.mem_i_vis_addr !== 17'h300) begin n_fail++; $display("FAIL sim_i_second: got %h want 300", bus.mem_i_vis_addr); end
        tick();
        bus.mem_status = MEM_FINISHED;
        bus.mem_data   = 32'h0000_1111;
        #1;
        n_checks++; if ({bus.i_data_valid, bus.i_data} !== {1'b1, 32'h0000_1111}) begin n_fail++; $display("FAIL sim_i_data: got %b/%h want 1/00001111", bus.i_data_valid, bus.i_data); end
        tick();
        bus.mem_status   = ST_IDLE;
        bus.i_req_signal = MEM_NOP;
        #1;
        n_checks++; if ({bus.i_done, bus.d_done} !== 2'b10) begin n_fail++; $display("FAIL sim_i_done: got %b want 10", {bus.i_done, bus.d_done}); end
        tick();
    endtask

    task automatic test_starvation();
        logic [16:0] exp_addr;
        bus.i_req_signal = MEM_READ;
        bus.i_req_addr   = 17'h500;
        bus.d_req_signal = MEM_READ;
        bus.d_req_addr   = 17'h600;
        for (int arb = 1; arb <= 5; arb++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_addr = (arb == 5) ? 17'h500 : 17'h600;
`else
            exp_addr = 17'h600;
`endif
            tick();
            n_checks++; if (bus.mem_d_vis_addr !== exp_addr) begin n_fail++; $display("FAIL starve_arb%0d: got %h want %h", arb, bus.mem_d_vis_addr, exp_addr); end
            tick();
            bus.mem_status = MEM_FINISHED;
            tick();
            bus.mem_status = ST_IDLE;
            if (arb == 5) begin
                bus.i_req_signal = MEM_NOP;
                bus.d_req_signal = MEM_NOP;
            end
            tick();
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL starve_end_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_burst();
        bus.d_req_signal = MEM_READ_BURST;
        bus.d_req_addr   = 17'h40;
        bus.d_req_length = 4'd4;
        tick();
        tick();
        bus.mem_status = MEM_DATA_WORKING;
        tick();
        n_checks++; if (bus.d_beat_idx !== 4'd2) begin n_fail++; $display("FAIL rst_pre_beat: got %0d want 2", bus.d_beat_idx); end
        rst_n            = 1'b0;
        bus.d_req_signal = MEM_NOP;
        #1;
        n_checks++; if ({bus.mem_d_vis_signal, bus.mem_d_vis_addr} !== 19'h0) begin n_fail++; $display("FAIL rst_mid_bus: got %b/%h want 00/0", bus.mem_d_vis_signal, bus.mem_d_vis_addr); end
        n_checks++; if ({busy, bus.d_data_valid, bus.d_beat_idx} !== 6'h0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %b/%b/%0d want 0/0/0", busy, bus.d_data_valid, bus.d_beat_idx); end
        bus.mem_status = ST_IDLE;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if ({busy, bus.d_done} !== 2'b00) begin n_fail++; $display("FAIL rst_after%0d: got %b want 00", k, {busy, bus.d_done}); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_i_single_read();
        test_d_burst_read();
        test_d_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single-port main memory.
- Grants memory to one requester at a time and holds the grant for a whole transaction (single read, burst read or multi-beat write).
- Generates the per-beat address for multi-beat transactions, forwards read data and status to the owner, and returns a one-cycle done pulse.
- Data cache has priority; the optional starvation guard bounds instruction-fetch latency.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, data word width
ENTRY_INDEX_SIZE, 3, beat counter width is ENTRY_INDEX_SIZE+1
STARVE_LIMIT, 4, consecutive D grants tolerated while I waits (optional feature only)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req_signal  in  2  I-cache request type, MEM_NOP = none
i_req_addr  in  ADDR_WIDTH  I-cache base address
i_data  out  LEN  read data to I-cache
i_data_valid  out  1  i_data holds a beat this cycle
i_done  out  1  one-cycle I transaction-complete pulse
d_req_signal  in  2  D-cache request type
d_req_addr  in  ADDR_WIDTH  D-cache base address
d_req_length  in  ENTRY_INDEX_SIZE+1  write beat count
d_req_data_type  in  3  ONE_BYTE/TWO_BYTE/FOUR_BYTE
d_req_written_data  in  LEN  write word for beat d_beat_idx
d_beat_idx  out  ENTRY_INDEX_SIZE+1  beat currently driven to memory
d_data  out  LEN  read data to D-cache
d_data_valid  out  1  d_data holds a beat this cycle
d_done  out  1  one-cycle D transaction-complete pulse
mem_i_vis_signal  out  2  always MEM_NOP
mem_d_vis_signal  out  2  granted request type or MEM_NOP
mem_i_vis_addr  out  ADDR_WIDTH  current beat address
mem_d_vis_addr  out  ADDR_WIDTH  current beat address, same value
mem_length  out  ENTRY_INDEX_SIZE+1  latched length
mem_written_data  out  LEN  pass-through of d_req_written_data
mem_data_type  out  3  latched data type
mem_data  in  LEN  memory read word
mem_status  in  2  MEM_FINISHED / MEM_DATA_WORKING
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, owner cleared, beat counter 0, latches 0, starve counter 0.
- Reset outputs: all mem signals MEM_NOP, addresses 0, done/valid 0, d_beat_idx 0, busy 0.
- Reset mid-transaction aborts it; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If d_req_signal != MEM_NOP, grant D. Else if i_req_signal != MEM_NOP, grant I. Else stay.
  - On grant, latch owner, type, base address, length and data_type; clear beat counter; go to ISSUE.
  - Mem outputs MEM_NOP.
- ISSUE (1 cycle):
  - Drive mem_d_vis_signal = latched type.
  - Drive both addresses = base + 4*beat.
  - Beat counter increments at the edge; go to WAIT.
- WAIT, mem_status == MEM_DATA_WORKING:
  - Keep driving the type; address advances by 4 per cycle; counter increments.
- WAIT, mem_status == MEM_FINISHED:
  - Drive MEM_NOP combinationally in that same cycle so memory does not start a new transaction; go to DONE.
- WAIT, read types (MEM_READ, MEM_READ_BURST): every WAIT cycle, owner data = mem_data and owner valid = 1. This yields one beat per cycle, including the finishing cycle.
- WAIT, writes: no valid pulses.
- DONE (1 cycle): owner done = 1 (registered), mem MEM_NOP, then IDLE. The requester must drop its request at the end of DONE; IDLE re-samples after that.
- Simultaneous I and D requests in IDLE: D wins, unless the guard fires.
- A request that arrives during a transaction waits; the fields of the granted request are not re-sampled.
- Non-owner data, valid and done outputs are 0. i_data and d_data are 0 when not valid.
- Latency, single read: grant edge, then ISSUE, WAIT (valid, FINISHED), DONE; done arrives 3 cycles after the request is seen in IDLE.
- The beat counter saturates at all-ones and does not wrap. Addresses wrap modulo 2^ADDR_WIDTH.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- With: the counter increments on each D grant made while i_req_signal != MEM_NOP, and clears on any I grant.
- With: when counter == STARVE_LIMIT and I is requesting, the next IDLE grant goes to I even if D requests.
- Without: strict D priority; no counter logic.

Test Plan:
- Reset idle: rst_n low mid-burst at beat 2 -> outputs NOP/0 immediately; after release, busy=0 and no d_done.
- I single read: i_req_signal=MEM_READ, addr 0x100 -> mem_i/d_vis_addr=0x100 in ISSUE; i_data_valid for one cycle with mem_data; i_done 3 cycles after request.
- D burst read: MEM_READ_BURST at 0x40, memory returns WORKING, WORKING, FINISHED -> addresses 0x40,0x44,0x48,0x4C driven; 3 d_data_valid beats; one d_done; MEM_NOP in the FINISHED cycle.
- D write length 2, FOUR_BYTE at 0x200 -> d_beat_idx 0 then 1; mem_written_data follows; no d_data_valid; d_done after FINISHED.
- Simultaneous I and D single reads -> D served first, I granted in the IDLE after D's DONE; I served with no lost requests.
- Guard enabled, STARVE_LIMIT=4, I held while D re-requests continuously -> I granted on the 5th arbitration. Guard disabled -> I starves while D requests.
